// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types for mod_counter: counting mode and control state.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Behaviour at the terminal value. MODE_RSVD behaves as MODE_WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } cnt_mode_t;

    // Control state of the counter.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } cnt_state_t;

endpackage
`default_nettype wire

// File: rtl/prescale_tick.sv
`default_nettype none
// ============================================================================
// Module      : prescale_tick
// Description : Divides enabled cycles by (prescale + 1). tick is asserted
//               combinationally on the enabled cycle that completes a period.
// Ports       : clock    - system clock
//               reset_n  - asynchronous active-low reset
//               restart  - synchronous return of the divider to 0
//               en       - cycle to be counted
//               prescale - period minus one
//               tick     - period complete on this enabled cycle
// Revision    : 1.0 - initial release
// ============================================================================
module prescale_tick #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // >= rather than == so that lowering prescale below the running count
    // ends the current period at once instead of waiting for a wrap.
    assign tick = en && (cnt >= prescale);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : WIDTH-bit up/down counter with programmable terminal value,
//               wrap / saturate / one-shot modes, synchronous load and a
//               registered one-cycle terminal-count pulse.
// Build option: MOD_COUNTER_PRESCALE_EN - adds PRESCALE_W and the prescale
//               input; the counter then steps once every prescale+1 enabled
//               RUN cycles.
// Ports       : clock    - system clock
//               reset_n  - asynchronous active-low reset
//               clear    - sync clear to 0 / IDLE (highest priority)
//               start    - IDLE or DONE -> RUN
//               en       - count enable, honoured in RUN only
//               load     - sync load of load_val, state unchanged
//               load_val - value for load
//               limit    - terminal value, sampled every cycle
//               up       - 1 counts 0..limit, 0 counts limit..0
//               mode     - WRAP / SAT / ONESHOT (RSVD acts as WRAP)
//               prescale - step divider (MOD_COUNTER_PRESCALE_EN only)
//               q        - current count
//               tc       - registered terminal-event pulse
//               busy     - state is RUN
//               done     - state is DONE
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_W = 8
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic                  up,
    input  cnt_mode_t             mode,
`ifdef MOD_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    cnt_state_t       state;
    cnt_state_t       state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             step;
    logic             at_terminal;

`ifdef MOD_COUNTER_PRESCALE_EN
    logic run_en;
    logic restart;

    assign run_en  = (state == S_RUN) && en;
    // Any event that repositions the count, or being outside RUN, starts a
    // fresh prescale period so the first step is always a full period away.
    assign restart = clear | load | start | (state != S_RUN);

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .restart  (restart),
        .en       (run_en),
        .prescale (prescale),
        .tick     (step)
    );
`else
    assign step = (state == S_RUN) && en;
`endif

    // Up-counting uses >= so that a limit lowered below q mid-count is
    // treated as reached instead of running on through the full range.
    assign at_terminal = up ? (q >= limit) : (q == '0);

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        tc_nxt    = 1'b0;

        if (clear) begin
            q_nxt     = '0;
            state_nxt = S_IDLE;
        end else if (load) begin
            q_nxt = load_val;
        end else if (start && (state != S_RUN)) begin
            state_nxt = S_RUN;
            // From IDLE q is kept (so a preload survives); from DONE the
            // count restarts at the beginning of the range.
            if (state == S_DONE) begin
                q_nxt = up ? '0 : limit;
            end
        end else if (step) begin
            if (at_terminal) begin
                tc_nxt = 1'b1;
                case (mode)
                    MODE_SAT:     q_nxt = up ? limit : '0;
                    MODE_ONESHOT: state_nxt = S_DONE;
                    default:      q_nxt = up ? '0 : limit;
                endcase
            end else begin
                q_nxt = up ? q + 1'b1 : q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            q     <= '0;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            tc    <= tc_nxt;
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter
// Description : Self-checking bench for mod_counter (WIDTH=8). A driver
//               applies directed and random stimulus at the falling edge and
//               queues the expected outputs from a reference model; a
//               monitor compares them after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;
    import counter_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         clear, start, en, load, up;
    logic [W-1:0] load_val, limit;
    cnt_mode_t    mode;
    logic [W-1:0] q;
    logic         tc, busy, done;
`ifdef MOD_COUNTER_PRESCALE_EN
    logic [7:0]   prescale;
`endif

    always #5 clock = ~clock;

    mod_counter #(
        .WIDTH (W)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (clear),
        .start    (start),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .up       (up),
        .mode     (mode),
`ifdef MOD_COUNTER_PRESCALE_EN
        .prescale (prescale),
`endif
        .q        (q),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int q;
        bit tc;
        bit busy;
        bit done;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycle_no = 0;

    // Reference model: 0 = IDLE, 1 = RUN, 2 = DONE
    int m_q     = 0;
    int m_state = 0;
    int m_pcnt  = 0;
    int cur_pre = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cycle_no, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge and queue what the
    // outputs must show after the following rising edge.
    task automatic step_cycle(input bit c, input bit l, input int lv, input bit s,
                              input bit e, input int lim, input bit u, input int md);
        exp_t x;
        int   nq, ns;
        bit   ntc, run_en, tick, reached;
        @(negedge clock);
        reset_n  = 1'b1;
        clear    = c;
        load     = l;
        load_val = W'(lv);
        start    = s;
        en       = e;
        limit    = W'(lim);
        up       = u;
        mode     = cnt_mode_t'(md[1:0]);
`ifdef MOD_COUNTER_PRESCALE_EN
        prescale = 8'(cur_pre);
`endif
        nq  = m_q;
        ns  = m_state;
        ntc = 1'b0;

        // Enabled RUN cycles are grouped into periods of cur_pre+1; only
        // the last cycle of a period moves the count.
        run_en = (m_state == 1) && e;
`ifdef MOD_COUNTER_PRESCALE_EN
        tick = run_en && (m_pcnt == cur_pre);
        if (c || l || s || m_state != 1) m_pcnt = 0;
        else if (run_en) m_pcnt = tick ? 0 : m_pcnt + 1;
`else
        tick = run_en;
`endif

        if (c) begin
            nq = 0;
            ns = 0;
        end else if (l) begin
            nq = lv % 256;
        end else if (s && m_state != 1) begin
            ns = 1;
            if (m_state == 2) nq = u ? 0 : lim;
        end else if (tick) begin
            reached = u ? (m_q >= lim) : (m_q == 0);
            if (reached) begin
                ntc = 1'b1;
                if (md == 1)      nq = u ? lim : 0;   // saturate: sit at the end
                else if (md == 2) ns = 2;             // one-shot: freeze, finish
                else              nq = u ? 0 : lim;   // wrap to the far end
            end else begin
                nq = u ? (m_q + 1) & 255 : (m_q - 1) & 255;
            end
        end
        m_q     = nq;
        m_state = ns;
        x.q     = nq;
        x.tc    = ntc;
        x.busy  = (ns == 1);
        x.done  = (ns == 2);
        sb.push_back(x);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic async_reset();
        exp_t x;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_q", int'(q), 0);
        check("async_tc", int'(tc), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        m_q = 0; m_state = 0; m_pcnt = 0;
        x.q = 0; x.tc = 0; x.busy = 0; x.done = 0;
        sb.push_back(x);
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            cycle_no++;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("q", int'(q), x.q);
                check("tc", int'(tc), int'(x.tc));
                check("busy", int'(busy), int'(x.busy));
                check("done", int'(done), int'(x.done));
            end
        end
    end

    // Driver
    initial begin
        int lim, md, lv, pre_ok;
        bit u, c, l, s, e;
        reset_n = 1'b0; clear = 0; start = 0; en = 0; load = 0; up = 1;
        load_val = '0; limit = '0; mode = MODE_WRAP;
`ifdef MOD_COUNTER_PRESCALE_EN
        prescale = '0;
`endif
        #12;
        check("reset_q", int'(q), 0);
        check("reset_tc", int'(tc), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // 1: up-count wrap at 3
        step_cycle(1, 0, 0, 0, 0, 3, 1, 0);
        step_cycle(0, 0, 0, 1, 0, 3, 1, 0);
        repeat (10) step_cycle(0, 0, 0, 0, 1, 3, 1, 0);

        // 2: one-shot down count from 5, then restart from DONE
        step_cycle(1, 0, 0, 0, 0, 5, 0, 2);
        step_cycle(0, 1, 5, 0, 0, 5, 0, 2);
        step_cycle(0, 0, 0, 1, 0, 5, 0, 2);
        repeat (16) step_cycle(0, 0, 0, 0, 1, 5, 0, 2);
        step_cycle(0, 1, 2, 0, 1, 5, 0, 2);      // load while DONE
        step_cycle(0, 0, 0, 1, 0, 5, 0, 2);
        repeat (3) step_cycle(0, 0, 0, 0, 1, 5, 0, 2);

        // 3: saturate at 200, then lower the limit under the count
        step_cycle(1, 0, 0, 0, 0, 200, 1, 1);
        step_cycle(0, 1, 198, 0, 0, 200, 1, 1);
        step_cycle(0, 0, 0, 1, 0, 200, 1, 1);
        repeat (5) step_cycle(0, 0, 0, 0, 1, 200, 1, 1);
        repeat (3) step_cycle(0, 0, 0, 0, 1, 150, 1, 1);

        // 4: clear+load together mid-run, then async reset mid-count
        step_cycle(1, 0, 0, 0, 0, 20, 1, 0);
        step_cycle(0, 0, 0, 1, 0, 20, 1, 0);
        repeat (3) step_cycle(0, 0, 0, 0, 1, 20, 1, 0);
        step_cycle(1, 1, 9, 0, 1, 20, 1, 0);
        step_cycle(0, 0, 0, 1, 0, 20, 1, 0);
        repeat (7) step_cycle(0, 0, 0, 0, 1, 20, 1, 0);
        async_reset();
        step_cycle(0, 0, 0, 0, 1, 20, 1, 0);

        // 5: limit 0, continuous then toggled enable; load on a terminal event
        step_cycle(0, 0, 0, 1, 0, 0, 1, 0);
        repeat (4) step_cycle(0, 0, 0, 0, 1, 0, 1, 0);
        step_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        step_cycle(0, 0, 0, 0, 1, 0, 1, 0);
        step_cycle(0, 1, 0, 0, 1, 0, 1, 0);
        step_cycle(0, 0, 0, 0, 0, 0, 1, 0);

        // 6: full-range down wrap
        step_cycle(1, 0, 0, 0, 0, 255, 0, 0);
        step_cycle(0, 0, 0, 1, 0, 255, 0, 0);
        repeat (3) step_cycle(0, 0, 0, 0, 1, 255, 0, 0);

`ifdef MOD_COUNTER_PRESCALE_EN
        // 7: prescale 2, limit 2, wrap
        cur_pre = 2;
        step_cycle(1, 0, 0, 0, 0, 2, 1, 0);
        step_cycle(0, 0, 0, 1, 0, 2, 1, 0);
        repeat (12) step_cycle(0, 0, 0, 0, 1, 2, 1, 0);
        cur_pre = 0;
        step_cycle(1, 0, 0, 0, 0, 2, 1, 0);
`endif

        // Random phase
        lim = 5; md = 0; u = 1; pre_ok = 0;
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(99) < 2);
            l = ($urandom_range(99) < 4);
            s = (m_state != 1) && ($urandom_range(99) < 30);
            e = ($urandom_range(99) < 85);
            lv = ($urandom_range(1) == 0) ? $urandom_range(255) : $urandom_range(12);
            if ($urandom_range(99) < 5)
                lim = ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(12);
            if ($urandom_range(99) < 3) md = $urandom_range(3);
            if ($urandom_range(99) < 3) u = $urandom_range(1);
`ifdef MOD_COUNTER_PRESCALE_EN
            if (c) cur_pre = $urandom_range(3);
`endif
            step_cycle(c, l, lv, s, e, lim, u, md);
        end
        step_cycle(0, 0, 0, 0, 0, lim, u, md);

        repeat (3) @(negedge clock);
        check("queue_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
